// File: rtl/fb_port_scheduler.sv
// Framebuffer port scheduler: arbitrates the single-port 400x300 RGB222
// framebuffer between VGA scan-out reads (hard priority), a frame-clear
// engine and a host pixel-write port, and drives the 2x-replicated pixel
// stream to the DAC.
// Optional feature macro: FB_VBLANK_WR_ONLY_EN (restricts host and clear
// writes to vertical blanking lines for tear-free updates).
module fb_port_scheduler #(
    parameter int FB_W     = 400,
    parameter int FB_H     = 300,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int AW       = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   count_rgb,
    input  logic [9:0]    reset_count_rgb,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [8:0]    wr_x,
    input  logic [8:0]    wr_y,
    input  logic [5:0]    wr_data,
    input  logic          clear_req,
    input  logic [5:0]    clear_color,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [7:0]    wr_oob_cnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [5:0]    mem_wdata,
    input  logic [5:0]    mem_rdata,
    output logic [1:0]    red_1,
    output logic [1:0]    green_1,
    output logic [1:0]    blue_1
);

    localparam logic [AW-1:0] FbWidth  = AW'(FB_W);
    localparam logic [AW-1:0] LastAddr = AW'(FB_W * FB_H - 1);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] clrAddr_q;
    logic [5:0]    clrColor_q;
    logic [7:0]    oobCnt_q;
    logic          act1_q;
    logic          rdRet1_q;
    logic [5:0]    hold_q;
    logic [5:0]    hold_d;
    logic [5:0]    rgb_q;

    logic          active;
    logic          scanSlot;
    logic          writeSlot;
    logic          wrXfer;
    logic          wrInRange;
    logic          clrWrite;
    logic          clrLast;
    logic [AW-1:0] scanAddr;
    logic [AW-1:0] hostAddr;

    // Visible region and slot classification; even visible columns belong
    // to scan-out, every other cycle is free for writes.
    assign active   = (32'(count_rgb) < H_ACTIVE) && (32'(reset_count_rgb) < V_ACTIVE);
    assign scanSlot = active && !count_rgb[0];

`ifdef FB_VBLANK_WR_ONLY_EN
    assign writeSlot = !scanSlot && (32'(reset_count_rgb) >= V_ACTIVE);
`else
    assign writeSlot = !scanSlot;
`endif

    // Each source pixel covers a 2x2 block of screen pixels, so both
    // counters are halved before forming the row-major address.
    assign scanAddr = AW'(reset_count_rgb[9:1]) * FbWidth + AW'(count_rgb[10:1]);
    assign hostAddr = AW'(wr_y) * FbWidth + AW'(wr_x);

    assign wrInRange  = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
    assign wr_ready   = !rst && (state_q == RUN) && writeSlot;
    assign wrXfer     = wr_valid && wr_ready;
    assign clrWrite   = !rst && (state_q == CLEAR) && writeSlot;
    assign clrLast    = (clrAddr_q == LastAddr);
    assign clear_done = clrWrite && clrLast;
    assign clear_busy = (state_q == CLEAR);
    assign wr_oob_cnt = oobCnt_q;

    // RAM port mux: scan read first, then clear engine, then host write;
    // out-of-range host writes are swallowed without touching the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (scanSlot) begin
                mem_en   = 1'b1;
                mem_addr = scanAddr;
            end else if (clrWrite) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clrAddr_q;
                mem_wdata = clrColor_q;
            end else if (wrXfer && wrInRange) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = hostAddr;
                mem_wdata = wr_data;
            end
        end
    end

    // Clear engine state machine: a request in RUN latches the colour and
    // restarts the sweep; the sweep advances on every usable write slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            clrAddr_q  <= '0;
            clrColor_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        clrAddr_q  <= '0;
                        clrColor_q <= clear_color;
                    end
                end
                CLEAR: begin
                    if (clrWrite) begin
                        if (clrLast) begin
                            state_q   <= RUN;
                            clrAddr_q <= '0;
                        end else begin
                            clrAddr_q <= clrAddr_q + AW'(1);
                        end
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Saturating count of host writes dropped for out-of-range coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oobCnt_q <= '0;
        end else if (wrXfer && !wrInRange && (oobCnt_q != 8'hFF)) begin
            oobCnt_q <= oobCnt_q + 8'd1;
        end
    end

    // The hold register only takes RAM data in the cycle after a scan read,
    // so the odd column that follows re-shows the same source pixel.
    assign hold_d = rdRet1_q ? mem_rdata : hold_q;

    // Scan-out pipeline: the active flag and read-return marker travel one
    // stage, then the pixel lands in the output register two cycles after
    // the counters that requested it; blanking forces black.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act1_q   <= 1'b0;
            rdRet1_q <= 1'b0;
            hold_q   <= '0;
            rgb_q    <= '0;
        end else begin
            act1_q   <= active;
            rdRet1_q <= scanSlot;
            hold_q   <= hold_d;
            rgb_q    <= act1_q ? hold_d : 6'd0;
        end
    end

    assign red_1   = rgb_q[5:4];
    assign green_1 = rgb_q[3:2];
    assign blue_1  = rgb_q[1:0];

endmodule

// File: tb/tb_fb_port_scheduler.sv
// Testbench for fb_port_scheduler. A full-size instance is driven with
// directed and random counter/host/clear stimulus and compared against a
// behavioural model through a scoreboard; a reduced-size instance is used
// to sweep a complete clear and observe the completion pulse.
module tb_fb_port_scheduler;

   localparam int W    = 400;
   localparam int H    = 300;
   localparam int HA   = 800;
   localparam int VA   = 600;
   localparam int AW   = 17;
   localparam int NPIX = W * H;

   localparam int SW    = 20;
   localparam int SH    = 10;
   localparam int SHA   = 40;
   localparam int SVA   = 20;
   localparam int SAW   = 8;
   localparam int SNPIX = SW * SH;

   typedef struct packed {
      logic          en;
      logic          we;
      logic [AW-1:0] addr;
      logic [5:0]    wdata;
      logic          ready;
      logic          busy;
      logic          done;
      logic [7:0]    oob;
   } memExp_t;

   typedef struct {
      int         cyc;
      logic [5:0] rgb;
   } rgbExp_t;

   logic          clk;
   logic          rst;
   logic [10:0]   count_rgb;
   logic [9:0]    reset_count_rgb;
   logic          wr_valid;
   logic          wr_ready;
   logic [8:0]    wr_x;
   logic [8:0]    wr_y;
   logic [5:0]    wr_data;
   logic          clear_req;
   logic [5:0]    clear_color;
   logic          clear_busy;
   logic          clear_done;
   logic [7:0]    wr_oob_cnt;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [5:0]    mem_wdata;
   logic [5:0]    mem_rdata;
   logic [1:0]    red_1;
   logic [1:0]    green_1;
   logic [1:0]    blue_1;

   logic [10:0]    sCount;
   logic [9:0]     sLine;
   logic           sWrValid;
   logic           sWrReady;
   logic [8:0]     sWrX;
   logic [8:0]     sWrY;
   logic [5:0]     sWrData;
   logic           sClearReq;
   logic [5:0]     sClearColor;
   logic           sClearBusy;
   logic           sClearDone;
   logic [7:0]     sOob;
   logic           sMemEn;
   logic           sMemWe;
   logic [SAW-1:0] sMemAddr;
   logic [5:0]     sMemWdata;
   logic [5:0]     sMemRdata;
   logic [1:0]     sRed;
   logic [1:0]     sGreen;
   logic [1:0]     sBlue;

   logic [5:0] ram    [NPIX];
   logic [5:0] shadow [NPIX];

   memExp_t memQ[$];
   rgbExp_t rgbQ[$];

   int         cyc;
   int         total;
   int         bad;
   bit         mClearing;
   int         mClrAddr;
   logic [5:0] mClrColor;
   logic [5:0] mLast;
   int         mOob;

   fb_port_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .count_rgb       (count_rgb),
      .reset_count_rgb (reset_count_rgb),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_x            (wr_x),
      .wr_y            (wr_y),
      .wr_data         (wr_data),
      .clear_req       (clear_req),
      .clear_color     (clear_color),
      .clear_busy      (clear_busy),
      .clear_done      (clear_done),
      .wr_oob_cnt      (wr_oob_cnt),
      .mem_en          (mem_en),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .red_1           (red_1),
      .green_1         (green_1),
      .blue_1          (blue_1)
   );

   fb_port_scheduler #(
      .FB_W     (SW),
      .FB_H     (SH),
      .H_ACTIVE (SHA),
      .V_ACTIVE (SVA),
      .AW       (SAW)
   ) smallDut (
      .clk             (clk),
      .rst             (rst),
      .count_rgb       (sCount),
      .reset_count_rgb (sLine),
      .wr_valid        (sWrValid),
      .wr_ready        (sWrReady),
      .wr_x            (sWrX),
      .wr_y            (sWrY),
      .wr_data         (sWrData),
      .clear_req       (sClearReq),
      .clear_color     (sClearColor),
      .clear_busy      (sClearBusy),
      .clear_done      (sClearDone),
      .wr_oob_cnt      (sOob),
      .mem_en          (sMemEn),
      .mem_we          (sMemWe),
      .mem_addr        (sMemAddr),
      .mem_wdata       (sMemWdata),
      .mem_rdata       (sMemRdata),
      .red_1           (sRed),
      .green_1         (sGreen),
      .blue_1          (sBlue)
   );

   // Free-running pixel clock and cycle index shared by stimulus and monitor.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Framebuffer RAM behind the main instance: one-cycle read latency, and
   // junk on the data bus whenever no read was issued the cycle before.
   always @(posedge clk) begin
      if (mem_en === 1'b1 && mem_we === 1'b0 && int'(mem_addr) < NPIX)
         mem_rdata <= ram[mem_addr];
      else
         mem_rdata <= 6'($urandom);
      if (mem_en === 1'b1 && mem_we === 1'b1 && int'(mem_addr) < NPIX)
         ram[mem_addr] <= mem_wdata;
   end

   // Shared comparison: counts every check and reports any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Scoreboard monitor: on each falling edge, compare the port activity
   // expected for this cycle and any pixel due on the DAC in this cycle.
   always @(negedge clk) begin : monitor
      memExp_t e;
      rgbExp_t r;
      if (memQ.size() > 0) begin
         e = memQ.pop_front();
         checkOutput("mem_en", 32'(mem_en), 32'(e.en));
         if (e.en) begin
            checkOutput("mem_we", 32'(mem_we), 32'(e.we));
            checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
         end
         checkOutput("wr_ready", 32'(wr_ready), 32'(e.ready));
         checkOutput("clear_busy", 32'(clear_busy), 32'(e.busy));
         checkOutput("clear_done", 32'(clear_done), 32'(e.done));
         checkOutput("wr_oob_cnt", 32'(wr_oob_cnt), 32'(e.oob));
      end
      while (rgbQ.size() > 0 && rgbQ[0].cyc < cyc) void'(rgbQ.pop_front());
      if (rgbQ.size() > 0 && rgbQ[0].cyc == cyc) begin
         r = rgbQ.pop_front();
         checkOutput("rgb", 32'({red_1, green_1, blue_1}), 32'(r.rgb));
      end
   end

   // Drive one cycle of main-instance inputs and derive the expected port
   // activity and pixel from the scheduling rules, then advance one clock.
   task automatic applyStimulus(input int x, input int y, input bit wv, input int wx, input int wy,
                                input logic [5:0] wd, input bit creq, input logic [5:0] ccol,
                                output bit accepted);
      bit      active;
      bit      scan;
      bit      window;
      bit      wasClearing;
      memExp_t e;
      rgbExp_t r;
      count_rgb       = 11'(x);
      reset_count_rgb = 10'(y);
      wr_valid        = wv;
      wr_x            = 9'(wx);
      wr_y            = 9'(wy);
      wr_data         = wd;
      clear_req       = creq;
      clear_color     = ccol;
      active      = (x < HA) && (y < VA);
      scan        = active && (x % 2 == 0);
`ifdef FB_VBLANK_WR_ONLY_EN
      window      = !scan && (y >= VA);
`else
      window      = !scan;
`endif
      wasClearing = mClearing;
      accepted    = 1'b0;
      e           = '0;
      e.busy      = mClearing;
      e.oob       = 8'(mOob);
      if (scan) begin
         e.en   = 1'b1;
         e.addr = AW'((y / 2) * W + x / 2);
         mLast  = shadow[(y / 2) * W + x / 2];
      end else if (window && mClearing) begin
         e.en    = 1'b1;
         e.we    = 1'b1;
         e.addr  = AW'(mClrAddr);
         e.wdata = mClrColor;
         shadow[mClrAddr] = mClrColor;
         if (mClrAddr == NPIX - 1) begin
            e.done    = 1'b1;
            mClearing = 1'b0;
            mClrAddr  = 0;
         end else begin
            mClrAddr++;
         end
      end else if (window) begin
         e.ready = 1'b1;
         if (wv) begin
            accepted = 1'b1;
            if (wx < W && wy < H) begin
               e.en    = 1'b1;
               e.we    = 1'b1;
               e.addr  = AW'(wy * W + wx);
               e.wdata = wd;
               shadow[wy * W + wx] = wd;
            end else if (mOob < 255) begin
               mOob++;
            end
         end
      end
      if (!wasClearing && creq) begin
         mClearing = 1'b1;
         mClrAddr  = 0;
         mClrColor = ccol;
      end
      r.cyc = cyc + 2;
      r.rgb = active ? mLast : 6'd0;
      memQ.push_back(e);
      rgbQ.push_back(r);
      @(posedge clk);
      #1;
   endtask

   // Assert reset in the middle of a cycle, confirm the outputs drop at
   // once, restart the model and release reset on a later cycle.
   task automatic applyReset(input int nCycles);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("reset_rgb", 32'({red_1, green_1, blue_1}), 32'd0);
      checkOutput("reset_wr_ready", 32'(wr_ready), 32'd0);
      checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
      checkOutput("reset_clear_busy", 32'(clear_busy), 32'd0);
      checkOutput("reset_wr_oob_cnt", 32'(wr_oob_cnt), 32'd0);
      mClearing = 1'b0;
      mClrAddr  = 0;
      mOob      = 0;
      mLast     = '0;
      memQ.delete();
      rgbQ.delete();
      repeat (nCycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Runaway guard in case the DUT stalls a bounded loop indefinitely.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: directed cases, random traffic, clear with abort, and
   // a complete clear sweep on the reduced instance.
   initial begin : stim
      bit         acc;
      bit         pend;
      int         px;
      int         py;
      int         sx;
      int         sy;
      int         n;
      logic [5:0] pd;
      logic [5:0] v;

      clk = 1'b0; rst = 1'b1; cyc = 0; total = 0; bad = 0;
      mClearing = 1'b0; mClrAddr = 0; mClrColor = '0; mLast = '0; mOob = 0;
      count_rgb = 11'd900; reset_count_rgb = 10'd610;
      wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
      clear_req = 1'b0; clear_color = '0;
      sCount = 11'(SHA + 5); sLine = 10'(SVA);
      sWrValid = 1'b0; sWrX = 9'd1; sWrY = 9'd1; sWrData = 6'h07;
      sClearReq = 1'b0; sClearColor = '0; sMemRdata = 6'h2D;
      for (int i = 0; i < NPIX; i++) begin
         v = 6'($urandom);
         ram[i] = v;
         shadow[i] = v;
      end
      ram[0] = 6'b110000; shadow[0] = 6'b110000;
      ram[1] = 6'b001100; shadow[1] = 6'b001100;

      @(posedge clk); #1;
      applyReset(3);

      // First two lines of the frame show the preloaded pixels twice over.
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            applyStimulus(x, y, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(2, 10, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(799, 599, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(798, 598, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(799, 599, 0, 0, 0, 6'h0, 0, 6'h0, acc);

      // Host write held across an even (scan) column, then out-of-range.
      applyStimulus(100, 50, 1, 5, 7, 6'h2A, 0, 6'h0, acc);
      applyStimulus(101, 50, 1, 5, 7, 6'h2A, 0, 6'h0, acc);
      applyStimulus(900, 0, 1, 400, 0, 6'h11, 0, 6'h0, acc);
      applyStimulus(10, 14, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(11, 14, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(12, 14, 0, 0, 0, 6'h0, 0, 6'h0, acc);

      // Write requested on an active odd column, waits for blanking if needed.
      acc = 1'b0;
      for (int i = 0; i < 8 && !acc; i++)
         applyStimulus((i < 4) ? 101 : 200, (i < 4) ? 100 : 600, 1, 9, 9, 6'h33, 0, 6'h0, acc);

      // Random traffic: mostly sequential scanning with occasional jumps.
      pend = 1'b0; px = 0; py = 0; pd = '0; sx = 0; sy = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            px = ($urandom_range(0, 4) == 0) ? int'($urandom_range(400, 511)) : int'($urandom_range(0, 399));
            py = ($urandom_range(0, 4) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 299));
            pd = 6'($urandom);
         end
         if ($urandom_range(0, 49) == 0) begin
            sx = $urandom_range(0, 1055);
            sy = $urandom_range(0, 627);
         end else begin
            sx++;
            if (sx >= 1056) begin sx = 0; sy = (sy + 1) % 628; end
         end
         applyStimulus(sx, sy, pend, px, py, pd, 0, 6'h0, acc);
         if (acc) pend = 1'b0;
      end

      // Clear requested together with a host write, then run the sweep over
      // active and blanking lines with a write and stray requests pending.
      applyStimulus(900, 610, 1, 3, 4, 6'h11, 1, 6'h15, acc);
      sx = 0; sy = 596;
      for (int i = 0; i < 20000 && mClrAddr < 5000; i++) begin
         sx++;
         if (sx >= 1056) begin sx = 0; sy = (sy + 1) % 628; end
         applyStimulus(sx, sy, 1, 10, 10, 6'h3F, (i % 997) == 5, 6'h2A, acc);
      end
      total++;
      if (mClrAddr < 5000) begin
         bad++;
         $display("[TB] FAIL clear_progress cycle=%0d got=%0d expected=5000", cyc, mClrAddr);
      end
      applyReset(2);
      applyStimulus(900, 610, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(0, 0, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(1, 0, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(400, 24, 0, 0, 0, 6'h0, 0, 6'h0, acc);
      applyStimulus(401, 24, 1, 20, 20, 6'h01, 0, 6'h0, acc);
      for (int i = 0; i < 300; i++)
         applyStimulus($urandom_range(0, 1055), $urandom_range(0, 627), 1,
                       $urandom_range(0, 399), $urandom_range(0, 299), 6'($urandom), 0, 6'h0, acc);
      wr_valid = 1'b0;

      // Reduced instance: full clear sweep, reads still served, one done pulse.
      sClearReq = 1'b1; sClearColor = 6'h15;
      @(posedge clk); #1;
      sClearReq = 1'b0; sWrValid = 1'b1;
      n = 0;
      for (int i = 0; i < 600 && n < SNPIX; i++) begin
         if (i % 3 == 0) begin
            sCount = 11'(2 * ((i / 3) % SW));
            sLine  = 10'((i / 3) % SVA);
         end else begin
            sCount = 11'(SHA + 5);
            sLine  = 10'(SVA);
         end
         #3;
         checkOutput("s_mem_en", 32'(sMemEn), 32'd1);
         if (i % 3 == 0) begin
            checkOutput("s_mem_we", 32'(sMemWe), 32'd0);
            checkOutput("s_mem_addr", 32'(sMemAddr), 32'((((i / 3) % SVA) / 2) * SW + (i / 3) % SW));
            checkOutput("s_clear_done", 32'(sClearDone), 32'd0);
         end else begin
            checkOutput("s_mem_we", 32'(sMemWe), 32'd1);
            checkOutput("s_mem_addr", 32'(sMemAddr), 32'(n));
            checkOutput("s_mem_wdata", 32'(sMemWdata), 32'h15);
            checkOutput("s_clear_done", 32'(sClearDone), 32'(n == SNPIX - 1));
            n++;
         end
         checkOutput("s_wr_ready", 32'(sWrReady), 32'd0);
         checkOutput("s_clear_busy", 32'(sClearBusy), 32'd1);
         checkOutput("s_rgb", 32'({sRed, sGreen, sBlue}),
                     (i >= 2 && (i - 2) % 3 == 0) ? 32'h2D : 32'h0);
         @(posedge clk); #1;
      end
      checkOutput("s_clear_count", 32'(n), 32'(SNPIX));
      sCount = 11'(SHA + 5); sLine = 10'(SVA);
      #3;
      checkOutput("s_clear_busy_after", 32'(sClearBusy), 32'd0);
      checkOutput("s_clear_done_after", 32'(sClearDone), 32'd0);
      checkOutput("s_wr_ready_after", 32'(sWrReady), 32'd1);
      checkOutput("s_wr_oob_cnt", 32'(sOob), 32'd0);
      @(posedge clk); #1;
      sWrValid = 1'b0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fb_port_scheduler.md
Name: fb_port_scheduler

Overview:
Sequences the single-port 400x300 framebuffer RAM (6-bit RGB222 per source pixel) that feeds the 800x600 VGA output with 2x pixel replication. Display scan-out reads get hard priority. A frame-clear engine and a host pixel-write port share the remaining free cycles. The block sits between the VGA timing counters and the framebuffer RAM, and drives red_1/green_1/blue_1 to the DAC pins.

Parameters:
FB_W, 400, framebuffer width in source pixels
FB_H, 300, framebuffer height in source pixels
H_ACTIVE, 800, visible columns of count_rgb
V_ACTIVE, 600, visible lines of reset_count_rgb
AW, 17, RAM address width (FB_W*FB_H-1 = 119999 fits)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
count_rgb  in  11  horizontal pixel counter from VGA timing
reset_count_rgb  in  10  vertical line counter from VGA timing
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle when wr_valid is also high
wr_x  in  9  host source-pixel column
wr_y  in  9  host source-pixel row
wr_data  in  6  {r[1:0],g[1:0],b[1:0]}
clear_req  in  1  one-cycle pulse: fill frame with clear_color
clear_color  in  6  fill value, sampled when clear_req is accepted
clear_busy  out  1  clear engine active
clear_done  out  1  one-cycle pulse when the last clear write is issued
wr_oob_cnt  out  8  saturating count of dropped out-of-range writes
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  6  RAM write data
mem_rdata  in  6  RAM read data, valid 1 cycle after a read is issued
red_1  out  2  DAC red
green_1  out  2  DAC green
blue_1  out  2  DAC blue

Behaviour:
- Reset (async, active-high): all outputs 0; state RUN; clear address 0; wr_oob_cnt 0; pipeline valid flags 0.
- Active region: count_rgb < H_ACTIVE and reset_count_rgb < V_ACTIVE.
- Scan slot: active region and count_rgb[0]==0.
  - Issue a read: mem_en=1, mem_we=0, mem_addr = (reset_count_rgb>>1)*FB_W + (count_rgb>>1).
  - The multiply/add is computed at full AW width; there is no truncation.
  - Odd lines re-read the same row as the line before.
- Free slot: any cycle that is not a scan slot. Priority within a free slot: clear engine > host write > idle (mem_en=0).
- Read pipeline:
  - Stage 1 registers the active flag.
  - Stage 2 captures mem_rdata into a hold register on read-return cycles only.
  - RGB outputs are registered from the hold register. Each source pixel therefore appears on two consecutive columns.
  - Total latency: RGB at cycle t+2 corresponds to the counters at cycle t. The timing generator compensates.
  - When the stage-2 active flag is 0, the RGB outputs are 0.
- Host write:
  - wr_ready is combinational: state RUN and free slot.
  - Transfer occurs when wr_valid && wr_ready. The RAM write is issued in the same cycle with mem_addr = wr_y*FB_W + wr_x.
  - If wr_x >= FB_W or wr_y >= FB_H: the transfer is accepted, no RAM write is issued (mem_en=0), and wr_oob_cnt increments, saturating at 255.
  - The host must hold wr_* stable while wr_valid is high and wr_ready is low.
- State machine:
  - RUN to CLEAR on clear_req; latch clear_color and set clear address to 0.
  - CLEAR: every free slot writes clear_color to the clear address, then increments it. wr_ready=0 throughout; clear_busy=1.
  - On the write to address FB_W*FB_H-1: pulse clear_done in the same cycle and return to RUN next cycle.
  - clear_req while in CLEAR is ignored.
  - clear_req arriving together with wr_valid in RUN: the host write in that cycle still completes if wr_ready=1; CLEAR starts next cycle.
- Reset mid-clear aborts the clear. State RUN, address 0, and the RAM contents are left partially cleared.

Optional Feature:
Macro FB_VBLANK_WR_ONLY_EN.
- Defined: host writes and clear writes are allowed only when reset_count_rgb >= V_ACTIVE, which gives tear-free updates. During active lines, wr_ready=0 and the clear engine pauses holding its address.
- Undefined: every free slot is usable, as described above.

Test Plan:
- Reset asserted mid-frame -> RGB outputs, wr_ready, mem_en, clear_busy all 0 immediately; wr_oob_cnt 0.
- Preload RAM[0]=6'b110000, RAM[1]=6'b001100; counters (0..3, 0) -> red_1=3 at t+2 and t+3, green_1=3 at t+4 and t+5; line 1 repeats the same values.
- Counters at (2,10) -> mem_addr=5*400+1=2001 read; counters (799,599) -> no read; at (798,598) address 119999.
- wr_valid with (x=5,y=7,data=6'h2A) held through an even active column -> wr_ready=0 that cycle, write on next odd column to addr 2805 with data 0x2A; write (x=400,y=0) -> accepted, no mem_en, wr_oob_cnt=1.
- clear_req with color 6'h15 during blanking -> 120000 writes, clear_done single pulse, wr_ready=0 throughout, reads still served on scan slots; reset at clear address 5000 -> RUN, clear_busy=0.
- With FB_VBLANK_WR_ONLY_EN: wr_valid at line 100 odd column -> wr_ready=0 until line 600, then the write completes.
